// File: rtl/brake_trig_pkg.sv
// Shared types and constants for the brake-light trigger and the frame-stop path.
package brake_trig_pkg;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_FIRE     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } trig_state_e;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  // RGB565 field positions {R5,G6,B5}
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  function automatic logic rgb_is_red(input logic [15:0] px,
                                      input logic [4:0]  r_min,
                                      input logic [5:0]  g_max,
                                      input logic [4:0]  b_max);
    return (px[R_MSB:R_LSB] >= r_min) &&
           (px[G_MSB:G_LSB] <= g_max) &&
           (px[B_MSB:B_LSB] <= b_max);
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Vertical-visible edge detector: one-cycle pulses when the raster leaves
// (frame_end) or re-enters (frame_start) the visible rows.
module frame_edge_det
  import brake_trig_pkg::*;
(
  input  logic       vga_pclk,
  input  logic       reset,
  input  logic [9:0] y_pixel_i,
  output logic       frame_end_o,
  output logic       frame_start_o
);

  logic yen_d;
  logic yen_q;

  assign yen_d = (y_pixel_i < 10'(V_VISIBLE));

  // Remember whether the previous cycle was on a visible row
  always_ff @(posedge vga_pclk or posedge reset) begin
    if (reset) yen_q <= 1'b0;
    else       yen_q <= yen_d;
  end

  assign frame_end_o   = yen_q & ~yen_d;
  assign frame_start_o = ~yen_q & yen_d;

endmodule

// File: rtl/brake_trigger_detect.sv
// Counts brake-red pixels inside the ROI per frame and pulses f2s_en after
// CONSEC_FRAMES consecutive hit frames, gated by the stop block's activity.
module brake_trigger_detect
  import brake_trig_pkg::*;
#(
  parameter int unsigned X_MIN           = 160,
  parameter int unsigned X_MAX           = 479,
  parameter int unsigned Y_MIN           = 120,
  parameter int unsigned Y_MAX           = 359,
  parameter logic [4:0]  R_MIN           = 5'd20,
  parameter logic [5:0]  G_MAX           = 6'd24,
  parameter logic [4:0]  B_MAX           = 5'd12,
  parameter int unsigned PIX_THRESH      = 2000,
  parameter int unsigned CONSEC_FRAMES   = 3,
  parameter int unsigned COOLDOWN_FRAMES = 60
) (
  input  logic        vga_pclk,
  input  logic        reset,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        de,
  input  logic [15:0] pix_rgb565,
  input  logic        stop_active,
  output logic        f2s_en,
  output logic [18:0] red_count,
  output logic [2:0]  hit_streak,
  output logic        led_armed
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES + 1);

  logic              frame_end;
  logic              frame_start;
  logic              roi_hit;
  logic              is_red;
  logic [18:0]       acc_base;
  logic [18:0]       acc_d,       acc_q;
  logic [18:0]       red_count_q;
  logic              fe_dly_q;
  logic              eval_q;
  logic              hit_d,       hit_q;
  trig_state_e       state_d,     state_q;
  logic [2:0]        streak_d,    streak_q;
  logic [CNT_W-1:0]  cnt_d,       cnt_q;
  logic              seen_d,      seen_q;
  logic              f2s_en_d,    f2s_en_q;
  logic              led_armed_d, led_armed_q;

  frame_edge_det u_edge (
    .vga_pclk      (vga_pclk),
    .reset         (reset),
    .y_pixel_i     (y_pixel),
    .frame_end_o   (frame_end),
    .frame_start_o (frame_start)
  );

  assign roi_hit = (x_pixel >= 10'(X_MIN)) && (x_pixel <= 10'(X_MAX)) &&
                   (y_pixel >= 10'(Y_MIN)) && (y_pixel <= 10'(Y_MAX));
  assign is_red  = de && roi_hit && rgb_is_red(pix_rgb565, R_MIN, G_MAX, B_MAX);
  assign hit_d   = (red_count_q >= 19'(PIX_THRESH));

  // Saturating red-pixel accumulator; restarting at frame_start is a no-op
  // for any ROI inside the visible rows since blanking cannot add counts
  always_comb begin
    acc_base = frame_start ? '0 : acc_q;
    acc_d    = acc_base;
    if (frame_end)                     acc_d = '0;
    else if (is_red && acc_base != '1) acc_d = acc_base + 19'd1;
  end

  // Accumulator, per-frame snapshot and the two-stage compare pipeline
  always_ff @(posedge vga_pclk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      red_count_q <= '0;
      fe_dly_q    <= 1'b0;
      eval_q      <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      if (frame_end) red_count_q <= acc_q;
      fe_dly_q <= frame_end;
      eval_q   <= fe_dly_q;
      hit_q    <= hit_d;
    end
  end

  // Trigger FSM next-state, streak, frame counter and output decode
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    case (state_q)
      ST_ARMED: begin
        if (stop_active) begin
          state_d  = ST_HOLD;
          streak_d = '0;
          cnt_d    = '0;
          seen_d   = 1'b1;
        end else if (eval_q) begin
          if (!hit_q) begin
            streak_d = '0;
          end else if (streak_q == 3'(CONSEC_FRAMES - 1)) begin
            state_d  = ST_FIRE;
            streak_d = '0;
          end else if (streak_q != 3'(CONSEC_FRAMES)) begin
            streak_d = streak_q + 3'd1;
          end
        end
      end
      ST_FIRE: begin
        state_d  = ST_HOLD;
        streak_d = '0;
        cnt_d    = '0;
        seen_d   = 1'b0;
      end
      ST_HOLD: begin
        streak_d = '0;
        if (stop_active) seen_d = 1'b1;
        if (seen_q && !stop_active) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
        end else if (!seen_q && !stop_active && eval_q) begin
          // stop block never answered: give up after the second frame
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COOLDOWN: begin
        streak_d = '0;
        if (stop_active) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          seen_d  = 1'b1;
        end else if (eval_q) begin
          if (cnt_q == CNT_W'(COOLDOWN_FRAMES - 1)) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ARMED;
    endcase
    f2s_en_d    = (state_d == ST_FIRE);
    led_armed_d = (state_d == ST_ARMED);
  end

  // Trigger FSM registers and registered outputs
  always_ff @(posedge vga_pclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ARMED;
      streak_q    <= '0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      f2s_en_q    <= 1'b0;
      led_armed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      f2s_en_q    <= f2s_en_d;
      led_armed_q <= led_armed_d;
    end
  end

  assign f2s_en     = f2s_en_q;
  assign red_count  = red_count_q;
  assign hit_streak = streak_q;
  assign led_armed  = led_armed_q;

endmodule

// File: doc/brake_trigger_detect.md
Name: brake_trigger_detect

Overview:
- Upstream stage of the 4-second frame-stop block. It watches the live camera pixel stream inside a region of interest (ROI) and counts "brake-red" pixels in each frame.
- When enough frames in a row exceed a pixel threshold, it issues the one-cycle f2s_en pulse that arms the stop block.
- It uses the stop block's f2s_val_out, fed back as stop_active, to suppress retriggering while a stop is in progress and for a cooldown afterwards.

Parameters:
- X_MIN, 160, ROI left column, inclusive.
- X_MAX, 479, ROI right column, inclusive.
- Y_MIN, 120, ROI top row, inclusive.
- Y_MAX, 359, ROI bottom row, inclusive.
- R_MIN, 5'd20, minimum R5 for a red pixel.
- G_MAX, 6'd24, maximum G6 for a red pixel.
- B_MAX, 5'd12, maximum B5 for a red pixel.
- PIX_THRESH, 2000, minimum red pixels per frame for a hit frame.
- CONSEC_FRAMES, 3, consecutive hit frames needed to fire.
- COOLDOWN_FRAMES, 60, frames ignored after stop_active falls.

Ports:
- vga_pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- x_pixel  in  10  current column
- y_pixel  in  10  current row; visible when below 480
- de  in  1  display enable, pixel valid
- pix_rgb565  in  16  camera pixel {R5,G6,B5}
- stop_active  in  1  f2s_val_out from the frame-stop block
- f2s_en  out  1  one-cycle trigger pulse to the frame-stop block
- red_count  out  19  red-pixel count of the last completed frame
- hit_streak  out  3  current run of consecutive hit frames
- led_armed  out  1  high in state ARMED

Behaviour:
- Reset values: f2s_en=0, red_count=0, hit_streak=0, led_armed=0, state=ARMED, all internal counters 0.
- Red pixel: de=1, ROI hit (X_MIN<=x<=X_MAX and Y_MIN<=y<=Y_MAX), R>=R_MIN, G<=G_MAX and B<=B_MAX.
- Accumulator:
  - 19-bit; increments by 1 per red pixel, registered.
  - Saturates at 19'h7FFFF and never wraps.
- Frame end (frame_end): the first vga_pclk edge with y_pixel>=480 after a cycle with y_pixel<480. Detected with a registered yen = (y_pixel<480).
- On each frame_end:
  - red_count <= accumulator.
  - Accumulator clears to 0 on the same edge. A red pixel coincident with frame_end cannot occur, because the pixel is outside the visible area.
  - hit = (accumulator >= PIX_THRESH).
- hit_streak rules:
  - Increments on a hit frame, saturating at CONSEC_FRAMES.
  - Clears to 0 on a miss frame.
  - Is held at 0 outside ARMED.
- FSM states and transitions:
  - ARMED: when frame_end is taken with a hit and hit_streak==CONSEC_FRAMES-1, go to FIRE. If stop_active=1 while ARMED, go to HOLD without firing.
  - FIRE: f2s_en=1 for exactly this one cycle, hit_streak<=0, then go to HOLD unconditionally.
  - HOLD: wait for stop_active to fall 1->0. Because the stop block samples f2s_en and only raises f2s_val at the next visible line, HOLD tolerates stop_active=0 for up to one frame. If no rise is seen by the 2nd frame_end, go to COOLDOWN anyway.
  - COOLDOWN: a frame counter counts frame_ends. At COOLDOWN_FRAMES, clear the counter and go to ARMED. If stop_active rises during COOLDOWN, go back to HOLD.
- Latency: f2s_en asserts 2 cycles after the frame_end edge of the qualifying frame (compare stage, then FIRE).
- The accumulator and red_count run in every state; only triggering is gated.
- Reset mid-frame: everything clears. The first frame_end after reset evaluates a partial frame; this is accepted.
- de=0 inside the visible area (blanked camera) counts nothing.

Decomposition:
- Package brake_trig_pkg holds:
  - the typedef enum for ARMED/FIRE/HOLD/COOLDOWN (2 bits);
  - the H_VISIBLE=640 and V_VISIBLE=480 constants;
  - the RGB565 field-slice constants.
- One sub-module, frame_edge_det: registers yen and outputs frame_end/frame_start pulses. It is reusable by the frame-stop block.
- Pixel classify, accumulator and FSM live in the top module.

Test Plan:
- Solid red (R=31,G=0,B=0) fills the ROI for 3 frames, stop_active=0 -> red_count=76800 each frame; f2s_en pulses once, 2 cycles after the 3rd frame_end; hit_streak sequence 1,2,0.
- Red frames 1,1,0,1,1,1 -> single f2s_en after the 6th frame; hit_streak drops to 0 after frame 3.
- 1999 red pixels per frame for 5 frames -> no f2s_en; red_count=1999. Then 2000 per frame -> fires after 3 frames.
- After the fire, stop_active high for 230 frames then low; red stays present -> no f2s_en until 60 frame_ends after the fall, then a fire after 3 more hit frames.
- Red pixels only outside the ROI (x=100) and pixels with de=0 -> red_count=0 and no trigger.
- Reset asserted mid-frame during COOLDOWN -> all outputs 0 immediately, state ARMED, and normal firing after 3 hit frames.
